// File: rtl/signed_search_controller.sv
// Binary-search initiator: probes an external signed comparator with `guess` until it reports equal.
// Optional SEARCH_STATS_EN adds a probe_count output reporting the number of probes in the last search.
module signed_search_controller #(
  parameter int WIDTH       = 4,
  parameter int CMP_LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             greater,
  input  logic             equal,
  input  logic             less,
  output logic [WIDTH-1:0] guess,
  output logic             probe_active,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] found,
  output logic             error
`ifdef SEARCH_STATS_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] probe_count
`endif
);

  localparam int WCNT_W = (CMP_LATENCY > 0) ? $clog2(CMP_LATENCY + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(CMP_LATENCY);
  localparam logic signed [WIDTH:0] LO_INIT = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] HI_INIT = {2'b00, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, PROBE, DONE, ERR} state_t;

  state_t                  state, state_n;
  logic signed [WIDTH:0]   lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0]        guess_n, found_n;
  logic [WCNT_W-1:0]       wcnt, wcnt_n;
  logic                    error_r, error_n;
  logic                    accept, sample;
  logic signed [WIDTH:0]   guess_ext;
  logic                    flags_ok;

  // Floor midpoint; the sum needs one extra bit so lo+hi cannot overflow.
  function automatic logic [WIDTH-1:0] mid(input logic signed [WIDTH:0] a,
                                           input logic signed [WIDTH:0] b);
    logic signed [WIDTH+1:0] s;
    s = {a[WIDTH], a} + {b[WIDTH], b};
    return s[WIDTH:1];
  endfunction

  assign guess_ext = {guess[WIDTH-1], guess};
  assign flags_ok  = (greater ^ equal ^ less) & ~(greater & equal & less);
  assign accept    = (state == IDLE) && start;
  assign sample    = (state == PROBE) && (wcnt == WCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lo      <= '0;
      hi      <= '0;
      guess   <= '0;
      found   <= '0;
      wcnt    <= '0;
      error_r <= 1'b0;
    end else begin
      state   <= state_n;
      lo      <= lo_n;
      hi      <= hi_n;
      guess   <= guess_n;
      found   <= found_n;
      wcnt    <= wcnt_n;
      error_r <= error_n;
    end
  end

  always_comb begin
    state_n = state;
    lo_n    = lo;
    hi_n    = hi;
    guess_n = guess;
    found_n = found;
    wcnt_n  = wcnt;
    error_n = error_r;
    case (state)
      IDLE: begin
        if (start) begin
          lo_n    = LO_INIT;
          hi_n    = HI_INIT;
          guess_n = mid(LO_INIT, HI_INIT);
          wcnt_n  = '0;
          error_n = 1'b0;
          state_n = PROBE;
        end
      end
      PROBE: begin
        if (!sample) begin
          wcnt_n = wcnt + 1'b1;
        end else if (!flags_ok) begin
          error_n = 1'b1;
          state_n = ERR;
        end else if (equal) begin
          found_n = guess;
          state_n = DONE;
        end else begin
          // Narrow the interval; crossing bounds means the comparator contradicted itself.
          if (greater) hi_n = guess_ext - 1'b1;
          else         lo_n = guess_ext + 1'b1;
          if (lo_n > hi_n) begin
            error_n = 1'b1;
            state_n = ERR;
          end else begin
            guess_n = mid(lo_n, hi_n);
            wcnt_n  = '0;
          end
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign probe_active = (state == PROBE);
  assign busy         = (state == PROBE);
  assign done         = (state == DONE);
  assign error        = error_r;

`ifdef SEARCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         probe_count <= '0;
    else if (accept) probe_count <= '0;
    else if (sample) probe_count <= probe_count + 1'b1;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
